// File: rtl/display_pkg.sv
// Shared definitions for the eight-digit multiplexed seven-segment display:
// digit descriptor layout, blank pattern and the hex-to-segment table.
package display_pkg;

  localparam int EN_W       = 1;
  localparam int VAL_W      = 4;
  localparam int DP_W       = 1;
  localparam int DIGIT_W    = EN_W + VAL_W + DP_W;
  localparam int SEG_W      = 7;
  localparam int NUM_DIGITS = 8;
  localparam int IDX_W      = 3;

  // {en, value[3:0], dp} as presented on each d* port
  typedef struct packed {
    logic             en;
    logic [VAL_W-1:0] value;
    logic             dp;
  } digit_t;

  // All segments and anodes off (active-low outputs)
  localparam logic [7:0] BLANK = 8'hFF;

  // Segments {a,b,c,d,e,f,g}, active-low; b and d are the lowercase forms
  localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111,  // 7
    7'b0000000,  // 8
    7'b0000100,  // 9
    7'b0001000,  // A
    7'b1100000,  // b
    7'b0110001,  // C
    7'b1000010,  // d
    7'b0110000,  // E
    7'b0111000   // F
  };

endpackage

// File: rtl/display_mux_seg7_dec.sv
// Combinational hex digit to active-low seven-segment decoder.
module seg7_dec
  import display_pkg::*;
(
  input  logic [VAL_W-1:0] value,
  output logic [SEG_W-1:0] seg
);

  // Pure table lookup
  always_comb begin
    seg = SEG_TABLE[value];
  end

endmodule

// File: rtl/display_mux.sv
// Eight-digit time-multiplexed seven-segment display driver.
// A prescaler produces one tick every SCAN_DIV cycles; each tick advances the
// digit index. Anodes and segments are registered from the current index and
// the current inputs, so they follow either with exactly one cycle of latency.
// Optional leading-zero blanking is compiled in with DISPLAY_MUX_LZB_EN.
module display_mux
  import display_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [DIGIT_W-1:0] d1,
  input  logic [DIGIT_W-1:0] d2,
  input  logic [DIGIT_W-1:0] d3,
  input  logic [DIGIT_W-1:0] d4,
  input  logic [DIGIT_W-1:0] d5,
  input  logic [DIGIT_W-1:0] d6,
  input  logic [DIGIT_W-1:0] d7,
  input  logic [DIGIT_W-1:0] d8,
  output logic [7:0]         an,
  output logic [7:0]         dec_ddp
);

  // SCAN_DIV=1 still needs a one-bit prescaler that simply stays at zero
  localparam int                 PRESC_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(SCAN_DIV - 1);

  digit_t             digits [NUM_DIGITS];
  digit_t             sel;
  logic [SEG_W-1:0]   seg;
  logic               blank;
  logic               tick;

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;
  logic [7:0]         an_q,    an_d;
  logic [7:0]         dec_q,   dec_d;

  assign digits[0] = digit_t'(d1);
  assign digits[1] = digit_t'(d2);
  assign digits[2] = digit_t'(d3);
  assign digits[3] = digit_t'(d4);
  assign digits[4] = digit_t'(d5);
  assign digits[5] = digit_t'(d6);
  assign digits[6] = digit_t'(d7);
  assign digits[7] = digit_t'(d8);

  // Prescaler wraps at SCAN_DIV-1; that cycle is the tick that moves the index
  always_comb begin
    tick    = (presc_q == PRESC_MAX);
    presc_d = tick ? '0 : presc_q + 1'b1;
    idx_d   = tick ? idx_q + 1'b1 : idx_q;
  end

`ifdef DISPLAY_MUX_LZB_EN
  logic [NUM_DIGITS-1:0] lzb_blank;

  // A zero digit is blanked while everything to its left is off or also blank-zero;
  // the rightmost digit is always shown
  always_comb begin : lzb_scan
    logic higher_clear;
    logic zero;
    lzb_blank    = '0;
    higher_clear = 1'b1;
    zero         = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero         = (digits[k].value == '0) && !digits[k].dp;
      lzb_blank[k] = digits[k].en && zero && higher_clear;
      higher_clear = higher_clear && (!digits[k].en || zero);
    end
  end
`endif

  // Select the digit under the current index and decide whether it is dark
  always_comb begin
    sel = digits[idx_q];
`ifdef DISPLAY_MUX_LZB_EN
    blank = !sel.en || lzb_blank[idx_q];
`else
    blank = !sel.en;
`endif
  end

  seg7_dec u_seg7_dec (
    .value (sel.value),
    .seg   (seg)
  );

  // Next anode / segment pattern; a dark position turns everything off
  always_comb begin
    an_d  = BLANK;
    dec_d = BLANK;
    if (!blank) begin
      an_d  = ~(8'd1 << idx_q);
      dec_d = {seg, ~sel.dp};
    end
  end

  // State and output registers; reset darkens the display immediately
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      idx_q   <= '0;
      an_q    <= BLANK;
      dec_q   <= BLANK;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      dec_q   <= dec_d;
    end
  end

  assign an      = an_q;
  assign dec_ddp = dec_q;

endmodule

// File: tb/tb_display_mux.sv
// Bench for display_mux: two instances (SCAN_DIV=4 and SCAN_DIV=1) share
// inputs; a reference model predicts both outputs every cycle.
module tb_display_mux;

  logic       clk;
  logic       rst;
  logic [5:0] din [8];
  logic [7:0] an4, dec4, an1, dec1;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 0;

  int          m4_cnt, m1_cnt;
  logic [15:0] e4, e1;

  logic [6:0] seg_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  typedef struct {
    logic [47:0] digs;   // {d8,...,d1}
    int          slot;
    logic [7:0]  an;
    logic [7:0]  dec;
  } vec_t;
  vec_t tbl [9];

  display_mux #(.SCAN_DIV(4)) dut4 (
    .clock(clk), .reset(rst),
    .d1(din[0]), .d2(din[1]), .d3(din[2]), .d4(din[3]),
    .d5(din[4]), .d6(din[5]), .d7(din[6]), .d8(din[7]),
    .an(an4), .dec_ddp(dec4)
  );

  display_mux #(.SCAN_DIV(1)) dut1 (
    .clock(clk), .reset(rst),
    .d1(din[0]), .d2(din[1]), .d3(din[2]), .d4(din[3]),
    .d5(din[4]), .d6(din[5]), .d7(din[6]), .d8(din[7]),
    .an(an1), .dec_ddp(dec1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {an, dec_ddp} after the n-th edge since reset (n counted from 0)
  function automatic logic [15:0] model(input int n, input int s);
    int         slot;
    logic [5:0] dg;
    bit         dark;
    bit         all_clear;
    slot = (n / s) % 8;
    dg   = din[slot];
    dark = !dg[5];
`ifdef DISPLAY_MUX_LZB_EN
    if (slot > 0 && dg[4:1] == 4'd0 && !dg[0]) begin
      all_clear = 1;
      for (int j = slot + 1; j < 8; j++)
        if (din[j][5] && !(din[j][4:1] == 4'd0 && !din[j][0])) all_clear = 0;
      if (all_clear) dark = 1;
    end
`else
    all_clear = 0;
`endif
    if (dark) return 16'hFFFF;
    return {~(8'd1 << slot), seg_tab[dg[4:1]], ~dg[0]};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m4_cnt <= 0;
      m1_cnt <= 0;
      e4     <= 16'hFFFF;
      e1     <= 16'hFFFF;
    end else begin
      e4     <= model(m4_cnt, 4);
      m4_cnt <= m4_cnt + 1;
      e1     <= model(m1_cnt, 1);
      m1_cnt <= m1_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: wait bound expired, got no match, expected one at %0t", name, $time);
  endtask

  // Advance to the next falling edge and compare both instances with the model
  task automatic tick();
    @(negedge clk);
    if (chk_en) begin
      check("model_an4",  an4,  e4[15:8]);
      check("model_dec4", dec4, e4[7:0]);
      check("model_an1",  an1,  e1[15:8]);
      check("model_dec1", dec1, e1[7:0]);
      check("onehot4", ($countones(~an4) <= 1) ? 8'd1 : 8'd0, 8'd1);
      check("onehot1", ($countones(~an1) <= 1) ? 8'd1 : 8'd0, 8'd1);
    end
  endtask

  task automatic set_all(input logic [5:0] v);
    for (int i = 0; i < 8; i++) din[i] = v;
  endtask

  task automatic wait_slot1(input int slot, input string name);
    int w;
    w = 0;
    while ((m1_cnt % 8) != slot && w < 10) begin
      tick();
      w++;
    end
    if ((m1_cnt % 8) != slot) timeout_fail(name);
  endtask

  function automatic logic [5:0] rand_digit();
    logic [5:0] r;
    r[5]   = ($urandom_range(0, 4) != 0);
    r[4:1] = ($urandom_range(0, 1) != 0) ? 4'd0 : 4'($urandom_range(0, 15));
    r[0]   = ($urandom_range(0, 3) == 0);
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    bit found;

    tbl[0] = '{{6'h30,6'h30,6'h30,6'h30,6'h30,6'h30,6'h2B,6'h20}, 0, 8'hFE, 8'h03};
    tbl[1] = '{{6'h30,6'h30,6'h30,6'h30,6'h30,6'h30,6'h2B,6'h20}, 1, 8'hFD, 8'h48};
    tbl[2] = '{{6'h30,6'h30,6'h30,6'h30,6'h30,6'h00,6'h30,6'h30}, 2, 8'hFF, 8'hFF};
    tbl[3] = '{{6'h30,6'h30,6'h30,6'h30,6'h30,6'h00,6'h30,6'h30}, 3, 8'hF7, 8'h01};
    tbl[4] = '{{6'h30,6'h30,6'h30,6'h3E,6'h30,6'h30,6'h30,6'h30}, 4, 8'hEF, 8'h71};
    tbl[5] = '{{6'h23,6'h30,6'h30,6'h30,6'h30,6'h30,6'h30,6'h30}, 7, 8'h7F, 8'h9E};
    tbl[6] = '{{6'h30,6'h36,6'h30,6'h30,6'h30,6'h30,6'h30,6'h30}, 6, 8'hBF, 8'hC1};
    tbl[7] = '{{6'h30,6'h30,6'h21,6'h30,6'h30,6'h30,6'h30,6'h30}, 5, 8'hDF, 8'h02};
    tbl[8] = '{{6'h30,6'h30,6'h30,6'h30,6'h3B,6'h30,6'h30,6'h30}, 3, 8'hF7, 8'h84};

    rst = 1'b1;
    set_all(6'h30);
    tick();
    tick();
    check("reset_an4",  an4,  8'hFF);
    check("reset_dec4", dec4, 8'hFF);
    check("reset_an1",  an1,  8'hFF);
    check("reset_dec1", dec1, 8'hFF);
    chk_en = 1;

    // Scan order with SCAN_DIV=4: each anode held four cycles, frame of 32
    rst = 1'b0;
    for (int n = 1; n <= 33; n++) begin
      tick();
      check("scan_order", an4, ~(8'd1 << (((n - 1) / 4) % 8)));
    end

    // Single-slot decode vectors on the SCAN_DIV=1 instance
    for (int i = 0; i < 9; i++) begin
      for (int k = 0; k < 8; k++) din[k] = tbl[i].digs[6*k +: 6];
      wait_slot1(tbl[i].slot, "tbl_align");
      tick();
      check($sformatf("tbl%0d_an", i),  an1,  tbl[i].an);
      check($sformatf("tbl%0d_dec", i), dec1, tbl[i].dec);
    end

    // Leading zeros: d8..d3 = 0, d2 = 7, d1 = 0
    set_all(6'h20);
    din[1] = 6'h2E;
    wait_slot1(0, "lzb_align");
    for (int s = 0; s < 8; s++) begin
      tick();
`ifdef DISPLAY_MUX_LZB_EN
      check("lzb_an",  an1,  (s >= 2) ? 8'hFF : ~(8'd1 << s));
      check("lzb_dec", dec1, (s >= 2) ? 8'hFF : ((s == 1) ? 8'h1F : 8'h03));
`else
      check("lzb_an",  an1,  ~(8'd1 << s));
      check("lzb_dec", dec1, (s == 1) ? 8'h1F : 8'h03);
`endif
    end

    // SCAN_DIV=1: d1 changed just after a tick edge shows at the next FE slot
    set_all(6'h30);
    wait_slot1(2, "d1chg_align");
    @(posedge clk);
    #1 din[0] = 6'h2B;
    found = 0;
    for (int w = 0; w < 10 && !found; w++) begin
      tick();
      if (an1 == 8'hFE) found = 1;
    end
    if (!found) timeout_fail("d1chg_wait");
    else check("d1chg_dec", dec1, 8'h48);

    // Reset pulsed mid-frame while the SCAN_DIV=4 instance shows slot 5
    set_all(6'h30);
    found = 0;
    for (int w = 0; w < 40 && !found; w++) begin
      tick();
      if (an4 == 8'hDF) found = 1;
    end
    if (!found) timeout_fail("midreset_wait");
    #2 rst = 1'b1;
    #1;
    check("async_an4",  an4,  8'hFF);
    check("async_dec4", dec4, 8'hFF);
    check("async_an1",  an1,  8'hFF);
    check("async_dec1", dec1, 8'hFF);
    tick();
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("release_an4", an4, 8'hFE);
    check("release_an1", an1, 8'hFE);

    // Random digit traffic
    for (int c = 0; c < 400; c++) begin
      tick();
      if (c % 100 == 0) begin
        for (int k = 0; k < 8; k++) din[k] = rand_digit();
      end else if ($urandom_range(0, 3) == 0) begin
        din[$urandom_range(0, 7)] = rand_digit();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
